// File: rtl/clock_wb_setter_pkg.sv
// Shared definitions for the push-button clock setter: bus offsets, FSM states, BCD helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package clock_wb_setter_pkg;

    // Responder register byte offsets. ALARM (0x0) exists on the responder but is never
    // accessed by this initiator, so only the two offsets it drives are defined here.
    localparam logic [7:0] ADR_TIME   = 8'h4;
    localparam logic [7:0] ADR_IRQCLR = 8'h8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_MOD  = 2'd2,
        ST_WR   = 2'd3
    } state_e;

    typedef enum logic {
        OP_MIN = 1'b0,
        OP_SEC = 1'b1
    } op_e;

    // MM:SS as four BCD digits, laid out exactly as in the TIME register low half.
    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    // Any digit that cannot occur in a valid MM:SS reading is forced to zero.
    function automatic bcd_time_t bcd_clean(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (r.min_tens > 4'd5) r.min_tens = 4'd0;
        if (r.min_ones > 4'd9) r.min_ones = 4'd0;
        if (r.sec_tens > 4'd5) r.sec_tens = 4'd0;
        if (r.sec_ones > 4'd9) r.sec_ones = 4'd0;
        return r;
    endfunction

    // Minutes +1 with wrap 59 -> 00; seconds pass through (cleaned).
    function automatic bcd_time_t bcd_inc_min(input bcd_time_t t);
        bcd_time_t r;
        r = bcd_clean(t);
        if (r.min_ones == 4'd9) begin
            r.min_ones = 4'd0;
            r.min_tens = (r.min_tens == 4'd5) ? 4'd0 : r.min_tens + 4'd1;
        end else begin
            r.min_ones = r.min_ones + 4'd1;
        end
        return r;
    endfunction

    // Seconds +1 with wrap 59 -> 00; never carries into minutes.
    function automatic bcd_time_t bcd_inc_sec(input bcd_time_t t);
        bcd_time_t r;
        r = bcd_clean(t);
        if (r.sec_ones == 4'd9) begin
            r.sec_ones = 4'd0;
            r.sec_tens = (r.sec_tens == 4'd5) ? 4'd0 : r.sec_tens + 4'd1;
        end else begin
            r.sec_ones = r.sec_ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_wb_setter_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, one-cycle rising-edge pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles + 1 registered pulse cycle.
// Backpressure: none; the pulse is fire-and-forget and the consumer must latch it.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it differed from the current one for DEBOUNCE_CYCLES
    // consecutive cycles; any bounce back to the old level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
            rise_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce state and edge pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/clock_wb_setter.sv
// Wishbone initiator turning debounced button presses into TIME read-modify-writes / IRQCLR writes.
// Latency: debounced press -> write ack in ~6 cycles with a 1-cycle-ack responder.
// Backpressure: waits on wb_ack_i; aborts after TIMEOUT_CYCLES without ack; presses merge while pending.
module clock_wb_setter
    import clock_wb_setter_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH   = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_min_i,
    input  logic                     btn_sec_i,
    input  logic                     btn_clr_i,
    input  logic                     irq_i,
    output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
    output logic [31:0]              wb_dat_o,
    input  logic [31:0]              wb_dat_i,
    output logic [3:0]               wb_sel_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    input  logic                     wb_ack_i,
    output logic                     busy_o,
    output logic                     alarm_o,
    output logic                     err_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_TIME   = WB_ADDR_WIDTH'(ADR_TIME);
    localparam logic [WB_ADDR_WIDTH-1:0] A_IRQCLR = WB_ADDR_WIDTH'(ADR_IRQCLR);

    logic min_rise, sec_rise, clr_rise;

    state_e                   state_q, state_d;
    op_e                      op_q, op_d;
    bcd_time_t                time_q, time_d, new_time;
    logic                     pend_min_q, pend_min_d;
    logic                     pend_sec_q, pend_sec_d;
    logic                     pend_clr_q, pend_clr_d;
    logic                     cyc_q, cyc_d;
    logic                     we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [31:0]              dat_q, dat_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic                     err_q, err_d;
    logic                     alarm_q, alarm_d;

    // Only the MM:SS half of TIME is meaningful to this block.
    logic unused_dat_hi;
    assign unused_dat_hi = ^wb_dat_i[31:16];

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_min (
        .clk(clk), .rst(rst), .btn_i(btn_min_i), .rise_o(min_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sec (
        .clk(clk), .rst(rst), .btn_i(btn_sec_i), .rise_o(sec_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk(clk), .rst(rst), .btn_i(btn_clr_i), .rise_o(clr_rise)
    );

    // Sequencer: arbitrate pending presses, drive the registered bus, watch for timeout.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        time_d     = time_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        new_time   = '0;
        pend_min_d = pend_min_q | min_rise;
        pend_sec_d = pend_sec_q | sec_rise;
        pend_clr_d = pend_clr_q | clr_rise;
        alarm_d    = alarm_q | irq_i;

        case (state_q)
            ST_IDLE: begin
                if (pend_clr_q) begin
                    pend_clr_d = 1'b0;
                    state_d    = ST_WR;
                    cyc_d      = 1'b1;
                    we_d       = 1'b1;
                    adr_d      = A_IRQCLR;
                    dat_d      = 32'h0;
                    tmo_d      = '0;
                    err_d      = 1'b0;
                end else if (pend_min_q || pend_sec_q) begin
                    if (pend_min_q) begin
                        pend_min_d = 1'b0;
                        op_d       = OP_MIN;
                    end else begin
                        pend_sec_d = 1'b0;
                        op_d       = OP_SEC;
                    end
                    state_d = ST_RD;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = A_TIME;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RD: begin
                if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    time_d  = bcd_time_t'(wb_dat_i[15:0]);
                    state_d = ST_MOD;
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_MOD: begin
                new_time = (op_q == OP_MIN) ? bcd_inc_min(time_q) : bcd_inc_sec(time_q);
                dat_d    = {16'h0, new_time};
                adr_d    = A_TIME;
                we_d     = 1'b1;
                cyc_d    = 1'b1;
                tmo_d    = '0;
                state_d  = ST_WR;
            end
            ST_WR: begin
                if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                    // Ack of the IRQCLR write wins over a still-high irq_i this cycle.
                    if (adr_q == A_IRQCLR) alarm_d = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state and registered bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MIN;
            time_q     <= '0;
            pend_min_q <= 1'b0;
            pend_sec_q <= 1'b0;
            pend_clr_q <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            time_q     <= time_d;
            pend_min_q <= pend_min_d;
            pend_sec_q <= pend_sec_d;
            pend_clr_q <= pend_clr_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            alarm_q    <= alarm_d;
        end
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_sel_o = cyc_q ? 4'hF : 4'h0;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign busy_o   = (state_q != ST_IDLE);
    assign alarm_o  = alarm_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_clock_wb_setter.sv
module tb_clock_wb_setter;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_min, btn_sec, btn_clr, irq;
    logic [3:0]  wb_adr_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic        busy_o, alarm_o, err_o;

    always #5 clk = ~clk;

    clock_wb_setter #(.WB_ADDR_WIDTH(4), .DEBOUNCE_CYCLES(20), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .btn_min_i(btn_min), .btn_sec_i(btn_sec), .btn_clr_i(btn_clr), .irq_i(irq),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i),
        .busy_o(busy_o), .alarm_o(alarm_o), .err_o(err_o)
    );

    // Responder model: TIME register, combinational 1-cycle ack, transaction log.
    logic        ack_en;
    logic        load_en;
    logic [15:0] load_val;
    logic [15:0] time_reg;
    logic        log_we  [0:255];
    logic [3:0]  log_adr [0:255];
    logic [31:0] log_dat [0:255];
    int          log_n    = 0;
    int          run      = 0;
    int          last_run = 0;

    assign wb_ack_i = wb_cyc_o & wb_stb_o & ack_en;
    assign wb_dat_i = (wb_adr_o == 4'h4) ? {16'h0, time_reg} : 32'h0;

    always @(posedge clk) begin
        if (load_en) begin
            time_reg <= load_val;
        end else if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
            if (log_n < 256) begin
                log_we[log_n[7:0]]  <= wb_we_o;
                log_adr[log_n[7:0]] <= wb_adr_o;
                log_dat[log_n[7:0]] <= wb_dat_o;
            end
            log_n <= log_n + 1;
            if (wb_we_o && wb_adr_o == 4'h4) time_reg <= wb_dat_o[15:0];
        end
        if (wb_cyc_o) begin
            run <= run + 1;
        end else if (run != 0) begin
            last_run <= run;
            run      <= 0;
        end
    end

    int errors = 0;
    int checks = 0;
    int base;
    logic [15:0] t0, t1, exp_t;
    bit          is_min;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: minutes/seconds as integers, illegal digits read as zero, modulo-60 increment.
    function automatic int digit(input logic [3:0] d, input int lim);
        return (int'(d) > lim) ? 0 : int'(d);
    endfunction

    function automatic logic [15:0] model_inc(input logic [15:0] t, input bit minute);
        int m, s;
        m = digit(t[15:12], 5) * 10 + digit(t[11:8], 9);
        s = digit(t[7:4], 5) * 10 + digit(t[3:0], 9);
        if (minute) m = (m + 1) % 60;
        else        s = (s + 1) % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_time(input logic [15:0] v);
        load_val = v;
        load_en  = 1'b1;
        tick(1);
        load_en  = 1'b0;
    endtask

    task automatic press(input bit m, input bit s, input bit c);
        btn_min = m; btn_sec = s; btn_clr = c;
        tick(30);
        btn_min = 1'b0; btn_sec = 1'b0; btn_clr = 1'b0;
        tick(30);
    endtask

    task automatic check_rd(input string tag, input int idx);
        check({tag, "_rd_we"},  32'(log_we[idx[7:0]]),  32'h0);
        check({tag, "_rd_adr"}, 32'(log_adr[idx[7:0]]), 32'h4);
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [3:0] adr, input logic [31:0] dat);
        check({tag, "_wr_we"},  32'(log_we[idx[7:0]]),  32'h1);
        check({tag, "_wr_adr"}, 32'(log_adr[idx[7:0]]), 32'(adr));
        check({tag, "_wr_dat"}, log_dat[idx[7:0]],      dat);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cyc"},   32'(wb_cyc_o), 32'h0);
        check({tag, "_stb"},   32'(wb_stb_o), 32'h0);
        check({tag, "_sel"},   32'(wb_sel_o), 32'h0);
        check({tag, "_we"},    32'(wb_we_o),  32'h0);
        check({tag, "_adr"},   32'(wb_adr_o), 32'h0);
        check({tag, "_dat"},   wb_dat_o,      32'h0);
        check({tag, "_busy"},  32'(busy_o),   32'h0);
        check({tag, "_alarm"}, 32'(alarm_o),  32'h0);
        check({tag, "_err"},   32'(err_o),    32'h0);
    endtask

    initial begin
        rst = 1'b1; btn_min = 1'b0; btn_sec = 1'b0; btn_clr = 1'b0; irq = 1'b0;
        ack_en = 1'b1; load_en = 1'b0; load_val = 16'h0;
        tick(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        tick(2);

        // 12:59 + 1 minute
        set_time(16'h1259);
        base = log_n;
        press(1'b1, 1'b0, 1'b0);
        check("t1_count", 32'(log_n - base), 32'd2);
        check_rd("t1", base);
        check_wr("t1", base + 1, 4'h4, 32'h0000_1359);
        check("t1_busy", 32'(busy_o), 32'h0);
        check("t1_err", 32'(err_o), 32'h0);

        // wrap cases
        set_time(16'h5959);
        base = log_n;
        press(1'b0, 1'b1, 1'b0);
        check("t2s_count", 32'(log_n - base), 32'd2);
        check_wr("t2s", base + 1, 4'h4, 32'h0000_5900);
        set_time(16'h5959);
        base = log_n;
        press(1'b1, 1'b0, 1'b0);
        check_wr("t2m", base + 1, 4'h4, 32'h0000_0059);

        // bouncing seconds button yields exactly one RMW
        set_time(16'h0305);
        base = log_n;
        for (int i = 0; i < 5; i++) begin
            btn_sec = 1'b1; tick(3);
            btn_sec = 1'b0; tick(3);
        end
        press(1'b0, 1'b1, 1'b0);
        check("t3_count", 32'(log_n - base), 32'd2);
        check_wr("t3", base + 1, 4'h4, 32'h0000_0306);

        // all three at once: clr, then min, then sec
        set_time(16'h0958);
        base = log_n;
        press(1'b1, 1'b1, 1'b1);
        check("t4_count", 32'(log_n - base), 32'd5);
        check_wr("t4_clr", base, 4'h8, 32'h0);
        check_rd("t4_min", base + 1);
        check_wr("t4_min", base + 2, 4'h4, 32'h0000_1058);
        check_rd("t4_sec", base + 3);
        check_wr("t4_sec", base + 4, 4'h4, 32'h0000_1059);
        check("t4_time", 32'(time_reg), 32'h1059);

        // timeout: no ack, no write, err set; recovery clears err
        ack_en = 1'b0;
        set_time(16'h2222);
        base = log_n;
        press(1'b1, 1'b0, 1'b0);
        check("t5_nowrite", 32'(log_n - base), 32'd0);
        check("t5_cyc_len", 32'(last_run), 32'd16);
        check("t5_err", 32'(err_o), 32'h1);
        check("t5_busy", 32'(busy_o), 32'h0);
        check("t5_time", 32'(time_reg), 32'h2222);
        ack_en = 1'b1;
        base = log_n;
        press(1'b0, 1'b1, 1'b0);
        check_wr("t5_rec", base + 1, 4'h4, 32'h0000_2223);
        check("t5_err_clr", 32'(err_o), 32'h0);

        // alarm set by irq pulse, cleared by IRQCLR write
        irq = 1'b1; tick(1); irq = 1'b0; tick(2);
        check("t6_alarm_set", 32'(alarm_o), 32'h1);
        base = log_n;
        press(1'b0, 1'b0, 1'b1);
        check("t6_count", 32'(log_n - base), 32'd1);
        check_wr("t6_clr", base, 4'h8, 32'h0);
        check("t6_alarm_clr", 32'(alarm_o), 32'h0);

        // randomized TIME values (including illegal digits) against the reference
        for (int i = 0; i < 12; i++) begin
            t0 = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 11)),
                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 11))};
            is_min = 1'($urandom_range(0, 1));
            exp_t  = model_inc(t0, is_min);
            set_time(t0);
            base = log_n;
            press(is_min, !is_min, 1'b0);
            check("rnd_count", 32'(log_n - base), 32'd2);
            check_wr("rnd", base + 1, 4'h4, {16'h0, exp_t});
        end

        // reset asserted during a read drops everything immediately; no retry afterwards
        ack_en = 1'b0;
        btn_min = 1'b1;
        for (int i = 0; i < 60 && !wb_cyc_o; i++) tick(1);
        check("t7_reached_rd", 32'(wb_cyc_o), 32'h1);
        btn_min = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("t7_rst");
        tick(3);
        rst = 1'b0;
        ack_en = 1'b1;
        base = log_n;
        tick(60);
        check("t7_no_retry", 32'(log_n - base), 32'd0);
        check("t7_busy", 32'(busy_o), 32'h0);

        t1 = time_reg;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
